divider32: RTL and testbench
============================

Name: divider32

Overview:
- Signed 32-bit integer divider with iterative (one quotient bit per clock) restoring shift-subtract datapath.
- Accepts a dividend/divisor pair on a `valid` pulse and returns quotient Q and remainder R with a `ready` flag about 34 cycles later.
- Division truncates toward zero (C semantics); a standalone arithmetic block for a datapath or CPU execute stage.

Parameters:
- WIDTH, 32, operand/result width (fixed at 32; parameter for documentation only).

Ports:
- clk  input  1  rising-edge clock.
- async_rst  input  1  reset; synchronous, active-high (port keeps the codebase name).
- valid  input  1  start request; operands sampled on the rising edge where valid=1.
- DIVIDEND  input  32  signed two's-complement dividend.
- DIVISOR  input  32  signed two's-complement divisor.
- Q  output  32  signed quotient, registered.
- R  output  32  signed remainder, registered.
- ready  output  1  high when Q/R hold the result of the last accepted request.

Behaviour:
- Reset: on a rising clk edge with async_rst=1: Q=0, R=0, ready=0, FSM=IDLE, iteration counter=0. Reset beats valid on the same edge.
- States: IDLE, CALC, FIX, DONE.
- Start:
  - On any edge with valid=1 and async_rst=0, in any state (including mid-operation or an unknown state), latch |DIVIDEND|, |DIVISOR|, both sign bits and the raw DIVIDEND.
  - Clear the partial remainder, set the counter to 32, set ready=0 and enter CALC.
  - A new valid aborts any operation in progress.
  - Operands are not re-sampled after the start edge.
- CALC, one edge per quotient bit, 32 edges:
  - Shift the 33-bit partial remainder left, bringing in the next dividend MSB.
  - If partial remainder ≥ |divisor|, subtract and set the quotient bit to 1, else 0.
  - Decrement the counter; after the 32nd bit go to FIX.
- FIX, 1 edge:
  - Q = quotient, negated if the dividend and divisor signs differ.
  - R = remainder, negated if the dividend is negative.
  - ready=1; go to DONE.
- Latency: start edge N → Q/R valid and ready=1 after edge N+34. This must be ≤ 39 cycles.
- DONE/IDLE: Q, R and ready hold indefinitely until the next valid or reset.
- valid held high for several cycles restarts each cycle; the result appears 34 edges after the last valid-high edge.
- Divisor = 0: Q=0xFFFFFFFF, R=DIVIDEND (raw, no sign fixup), same latency.
- Overflow (0x80000000 / 0xFFFFFFFF): Q=0x80000000 (wraps), R=0.
- Invariant for a nonzero divisor: DIVIDEND = Q*DIVISOR + R, |R| < |DIVISOR|, and R is 0 or has the dividend's sign.
- Q and R are stable (no glitching) while ready=1.

Decomposition:
- Shared package `divider_pkg`:
  - WIDTH=32, ITER=32, LATENCY=34.
  - FSM state enum {IDLE, CALC, FIX, DONE}.
- One natural sub-module: `divider32_core`, the unsigned 32-step restoring engine (magnitude in → unsigned quotient/remainder out, with a done strobe).
- The top level owns the abs/negate sign handling, the divide-by-zero override and the output registers.

Test Plan:
- Pos/pos: reset, then valid 1 cycle with 0x26A5515D / 0x000E895A → after ≤39 cycles ready=1, Q=0x000002A8, R=0x00087A4D.
- Neg/pos: 0xD5547562 / 0x000435CA → Q=0xFFFFF5DE, R=0xFFFD7E36.
- Pos/neg: 0x44B7495A / 0xFFFFD362 → Q=0xFFFE75BB, R=0x000016C4.
- Neg/neg: 0xD1D54D1D / 0xFFFE25EA → Q=0x000018ED, R=0xFFFE437B.
  - Run the four operations back-to-back, 40 cycles apart.
  - Each result must hold until the next valid.
- Corner cases:
  - 100 / 0 → Q=0xFFFFFFFF, R=100.
  - 0x80000000 / 0xFFFFFFFF → Q=0x80000000, R=0.
  - −7/2 → Q=−3, R=−1.
- Control:
  - Assert async_rst mid-CALC → next edge Q=0, R=0, ready=0.
  - Issue a second valid at cycle 10 of an operation → only the second result is reported, 34 edges after it; ready stays 0 in between.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared definitions for the signed 32-bit iterative divider.
//   WIDTH   : operand/result width
//   ITER    : quotient bits produced, one per clock
//   LATENCY : edges from the start edge to ready=1
//   state_t : top-level sequencing states
package divider_pkg;

   localparam int WIDTH   = 32;
   localparam int ITER    = 32;
   localparam int LATENCY = 34;
   localparam int CNT_W   = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Two's-complement magnitude; the most negative value maps to itself,
   // which is still its correct unsigned magnitude.
   function automatic logic [WIDTH-1:0] abs32(input logic [WIDTH-1:0] x);
      logic [WIDTH-1:0] v;
      if (x[WIDTH-1]) begin
         v = ~x + 32'd1;
      end else begin
         v = x;
      end
      return v;
   endfunction

   // Conditional two's-complement negation used for the sign fixup.
   function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic neg);
      logic [WIDTH-1:0] v;
      if (neg) begin
         v = ~x + 32'd1;
      end else begin
         v = x;
      end
      return v;
   endfunction

endpackage

// File: rtl/divider32_core.sv
// Unsigned restoring division engine: one quotient bit per clock.
// Ports:
//   clk            rising-edge clock
//   i_rst          synchronous active-high reset
//   i_start        load operands and restart (has priority over any run)
//   i_dividend_mag unsigned dividend magnitude
//   i_divisor_mag  unsigned divisor magnitude
//   o_quotient     unsigned quotient (valid when o_done pulses)
//   o_remainder    unsigned remainder (valid when o_done pulses)
//   o_done         one-cycle strobe after the final quotient bit
module divider32_core
   import divider_pkg::*;
(
   input  logic             clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_dividend_mag,
   input  logic [WIDTH-1:0] i_divisor_mag,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder,
   output logic             o_done
);

   logic [WIDTH:0]   r_rem;
   logic [WIDTH-1:0] r_quo;   // dividend bits shift out of the top, quotient bits in at the bottom
   logic [WIDTH-1:0] r_dvs;
   logic [CNT_W-1:0] r_cnt;
   logic             r_done;

   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_diff;
   logic             w_ge;

   // One restoring step: shift in the next dividend bit and trial-subtract.
   always_comb begin
      w_shift = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
      w_diff  = w_shift - {1'b0, r_dvs};
      w_ge    = (w_shift >= {1'b0, r_dvs});
   end

   // Iteration registers; a start always wins over a run in progress.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_rem  <= '0;
         r_quo  <= '0;
         r_dvs  <= '0;
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else if (i_start) begin
         r_rem  <= '0;
         r_quo  <= i_dividend_mag;
         r_dvs  <= i_divisor_mag;
         r_cnt  <= CNT_W'(ITER);
         r_done <= 1'b0;
      end else if (r_cnt != 6'd0) begin
         r_rem  <= w_ge ? w_diff : w_shift;
         r_quo  <= {r_quo[WIDTH-2:0], w_ge};
         r_cnt  <= r_cnt - 6'd1;
         r_done <= (r_cnt == 6'd1);
      end else begin
         r_done <= 1'b0;
      end
   end

   assign o_quotient  = r_quo;
   assign o_remainder = r_rem[WIDTH-1:0];   // remainder < divisor, so the top bit is always 0
   assign o_done      = r_done;

endmodule

// File: rtl/divider32.sv
// Signed 32-bit divider, truncating toward zero, 34 edges from start to result.
// Ports:
//   clk        rising-edge clock
//   async_rst  synchronous active-high reset (name kept from the codebase)
//   valid      start request; operands sampled on that edge, restarts any run
//   DIVIDEND   signed dividend
//   DIVISOR    signed divisor
//   Q          signed quotient, registered
//   R          signed remainder, registered
//   ready      Q/R hold the result of the last accepted request
module divider32
   import divider_pkg::*;
#(
   parameter int P_WIDTH = 32
)(
   input  logic             clk,
   input  logic             async_rst,
   input  logic             valid,
   input  logic [WIDTH-1:0] DIVIDEND,
   input  logic [WIDTH-1:0] DIVISOR,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             ready
);

   state_t           r_state;
   logic             r_sign_a;
   logic             r_sign_b;
   logic             r_div_zero;
   logic [WIDTH-1:0] r_dividend;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_r;
   logic             r_ready;

   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic [WIDTH-1:0] w_core_q;
   logic [WIDTH-1:0] w_core_r;
   logic             w_core_done;
   logic             w_start;

   // Operand magnitudes fed to the engine on the start edge.
   always_comb begin
      w_start = valid & ~async_rst;
      w_abs_a = abs32(DIVIDEND);
      w_abs_b = abs32(DIVISOR);
   end

   divider32_core u_core (
      .clk            (clk),
      .i_rst          (async_rst),
      .i_start        (w_start),
      .i_dividend_mag (w_abs_a),
      .i_divisor_mag  (w_abs_b),
      .o_quotient     (w_core_q),
      .o_remainder    (w_core_r),
      .o_done         (w_core_done)
   );

   // Sequencing FSM with sign fixup, divide-by-zero override and output registers.
   always_ff @(posedge clk) begin
      if (async_rst) begin
         r_state    <= IDLE;
         r_sign_a   <= 1'b0;
         r_sign_b   <= 1'b0;
         r_div_zero <= 1'b0;
         r_dividend <= '0;
         r_q        <= '0;
         r_r        <= '0;
         r_ready    <= 1'b0;
      end else if (valid) begin
         r_state    <= CALC;
         r_sign_a   <= DIVIDEND[WIDTH-1];
         r_sign_b   <= DIVISOR[WIDTH-1];
         r_div_zero <= (DIVISOR == 32'd0);
         r_dividend <= DIVIDEND;
         r_ready    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_state <= IDLE;
            end
            CALC: begin
               if (w_core_done) begin
                  r_state <= FIX;
               end else begin
                  r_state <= CALC;
               end
            end
            FIX: begin
               if (r_div_zero) begin
                  // Divide by zero reports all-ones and the raw dividend.
                  r_q <= 32'hFFFF_FFFF;
                  r_r <= r_dividend;
               end else begin
                  r_q <= neg_if(w_core_q, r_sign_a ^ r_sign_b);
                  r_r <= neg_if(w_core_r, r_sign_a);
               end
               r_ready <= 1'b1;
               r_state <= DONE;
            end
            DONE: begin
               r_state <= DONE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign Q     = r_q;
   assign R     = r_r;
   assign ready = r_ready;

endmodule

// File: tb/tb_divider32.sv
module tb_divider32;

   logic        clk;
   logic        async_rst;
   logic        valid;
   logic [31:0] DIVIDEND;
   logic [31:0] DIVISOR;
   logic [31:0] Q;
   logic [31:0] R;
   logic        ready;

   int checks = 0;
   int errors = 0;

   divider32 dut (
      .clk       (clk),
      .async_rst (async_rst),
      .valid     (valid),
      .DIVIDEND  (DIVIDEND),
      .DIVISOR   (DIVISOR),
      .Q         (Q),
      .R         (R),
      .ready     (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one valid pulse; returns 1 ns after the start edge.
   task automatic start_op(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      valid    = 1'b1;
      DIVIDEND = a;
      DIVISOR  = b;
      @(posedge clk);
      #1;
      valid = 1'b0;
   endtask

   // Start an operation and check exact latency and the result.
   task automatic run_and_check(input string name, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] eq, input logic [31:0] er);
      int early;
      early = 0;
      start_op(a, b);
      repeat (33) begin
         @(posedge clk);
         #1;
         if (ready !== 1'b0) early++;
      end
      checks++;
      if (early != 0) begin
         errors++;
         $display("FAIL %s_early_ready: ready seen high %0d times, required 0", name, early);
      end
      @(posedge clk);
      #1;
      checks++;
      if (ready !== 1'b1 || Q !== eq || R !== er) begin
         errors++;
         $display("FAIL %s: ready=%b Q=%h R=%h, required ready=1 Q=%h R=%h", name, ready, Q, R, eq, er);
      end
   endtask

   task automatic test_reset();
      async_rst = 1'b1;
      valid     = 1'b1;
      DIVIDEND  = 32'd50;
      DIVISOR   = 32'd5;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (ready !== 1'b0 || Q !== 32'd0 || R !== 32'd0) begin
         errors++;
         $display("FAIL reset: ready=%b Q=%h R=%h, required 0/0/0", ready, Q, R);
      end
      valid = 1'b0;
      @(negedge clk);
      async_rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (ready !== 1'b0 || Q !== 32'd0) begin
         errors++;
         $display("FAIL reset_idle: ready=%b Q=%h, required 0/0", ready, Q);
      end
   endtask

   // Four sign combinations, 40 cycles apart, each held until the next valid.
   task automatic test_back_to_back();
      logic [31:0] va[4] = '{32'h26A5515D, 32'hD5547562, 32'h44B7495A, 32'hD1D54D1D};
      logic [31:0] vb[4] = '{32'h000E895A, 32'h000435CA, 32'hFFFFD362, 32'hFFFE25EA};
      logic [31:0] vq[4] = '{32'h000002A8, 32'hFFFFF5DE, 32'hFFFE75BB, 32'h000018ED};
      logic [31:0] vr[4] = '{32'h00087A4D, 32'hFFFD7E36, 32'h000016C4, 32'hFFFE437B};
      for (int i = 0; i < 4; i++) begin
         run_and_check($sformatf("sign%0d", i), va[i], vb[i], vq[i], vr[i]);
         repeat (5) @(posedge clk);
         #1;
         checks++;
         if (ready !== 1'b1 || Q !== vq[i] || R !== vr[i]) begin
            errors++;
            $display("FAIL sign%0d_hold: ready=%b Q=%h R=%h, required 1 %h %h", i, ready, Q, R, vq[i], vr[i]);
         end
      end
   endtask

   task automatic test_corners();
      run_and_check("div_zero", 32'd100, 32'd0, 32'hFFFFFFFF, 32'd100);
      run_and_check("overflow", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
      run_and_check("m7_div_2", 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
      run_and_check("neg_div_zero", 32'hFFFFFF9C, 32'd0, 32'hFFFFFFFF, 32'hFFFFFF9C);
   endtask

   task automatic test_reset_mid();
      int seen;
      start_op(32'd1000, 32'd7);
      repeat (10) @(posedge clk);
      @(negedge clk);
      async_rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (ready !== 1'b0 || Q !== 32'd0 || R !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid: ready=%b Q=%h R=%h, required 0/0/0", ready, Q, R);
      end
      @(negedge clk);
      async_rst = 1'b0;
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (ready !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL reset_mid_abort: ready high %0d cycles, required 0", seen);
      end
   endtask

   // Second valid on cycle 10 of the first operation; only the second result appears.
   task automatic test_abort();
      int seen;
      run_and_check("pre_abort", 32'd100, 32'd7, 32'd14, 32'd2);
      start_op(32'd100000, 32'd3);
      seen = 0;
      repeat (9) begin
         @(posedge clk);
         #1;
         if (ready !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL abort_first_ready: ready high %0d cycles, required 0", seen);
      end
      run_and_check("abort_second", 32'hFFFFFF85, 32'd10, 32'hFFFFFFF4, 32'hFFFFFFFD);
   endtask

   // Valid held for three cycles: result 34 edges after the last valid-high edge.
   task automatic test_valid_held();
      @(negedge clk);
      valid    = 1'b1;
      DIVIDEND = 32'd77;
      DIVISOR  = 32'd4;
      repeat (2) @(posedge clk);
      run_and_check("valid_held", 32'd77, 32'd4, 32'd19, 32'd1);
   endtask

   initial begin
      async_rst = 1'b0;
      valid     = 1'b0;
      DIVIDEND  = 32'd0;
      DIVISOR   = 32'd0;
      test_reset();
      test_back_to_back();
      test_corners();
      test_reset_mid();
      test_abort();
      test_valid_held();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
